// File: rtl/neander_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : neander_mem_resp
// Purpose  : 256-word memory responder for the Neander CPU with wait states,
//            one-cycle ready pulse and an idle-time loader port.
//            Optional memory-mapped output register at 0xFF: NEANDER_MEM_IO_EN
// Revision : 1.0 - initial release
// ============================================================================
module neander_mem_resp #(
    parameter int WAIT_CYCLES = 1,
    parameter int DATA_W      = 8
) (
    input  logic              clock,
    input  logic              RESET,
    input  logic [7:0]        endM,
    input  logic [DATA_W-1:0] dataIN,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] dataOUT,
    output logic              ready,
    input  logic              ld_we,
    input  logic [7:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
`ifdef NEANDER_MEM_IO_EN
    output logic [DATA_W-1:0] io_out,
`endif
    output logic              ld_rdy
);

    // ACPT holds the freshly latched request for one cycle, so DONE is entered
    // WAIT_CYCLES+1 edges after the request was sampled.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACPT = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] C_CNT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [7:0]        r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_op_wr;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] r_mem [256];

    logic              w_to_done;
    logic              w_io_hit;
    logic              w_ld_we;
    logic              w_cpu_we;
    logic [DATA_W-1:0] w_rd_word;

    assign w_to_done = ((r_state == S_ACPT) && (WAIT_CYCLES == 0)) ||
                       ((r_state == S_BUSY) && (r_cnt == 4'd0));

`ifdef NEANDER_MEM_IO_EN
    logic [DATA_W-1:0] r_io;
    assign w_io_hit  = (r_addr == 8'hFF);
    assign w_rd_word = w_io_hit ? r_io : r_mem[r_addr];
    assign io_out    = r_io;
`else
    assign w_io_hit  = 1'b0;
    assign w_rd_word = r_mem[r_addr];
`endif

    assign w_ld_we  = ld_we && (r_state == S_IDLE) && !RESET;
    assign w_cpu_we = w_to_done && r_op_wr && !w_io_hit && !RESET;

    // Array contents survive reset; only the commit strobes are gated by it.
    always_ff @(posedge clock) begin
        if (w_ld_we) begin
            r_mem[ld_addr] <= ld_data;
        end else if (w_cpu_we) begin
            r_mem[r_addr] <= r_data;
        end
    end

    always_ff @(posedge clock) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 8'd0;
            r_data  <= '0;
            r_op_wr <= 1'b0;
            r_dout  <= '0;
`ifdef NEANDER_MEM_IO_EN
            r_io    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!ld_we && (write || read)) begin
                        r_addr  <= endM;
                        r_op_wr <= write;
                        if (write) begin
                            r_data <= dataIN;
                        end
                        r_state <= S_ACPT;
                    end
                end
                S_ACPT: begin
                    if (WAIT_CYCLES == 0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= C_CNT_LOAD;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_to_done) begin
                if (!r_op_wr) begin
                    r_dout <= w_rd_word;
                end
`ifdef NEANDER_MEM_IO_EN
                else if (w_io_hit) begin
                    r_io <= r_data;
                end
`endif
            end
        end
    end

    assign dataOUT = r_dout;
    assign ready   = (r_state == S_DONE);
    assign ld_rdy  = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_neander_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_neander_mem_resp
// Purpose  : Self-checking bench for neander_mem_resp at WAIT_CYCLES 0, 1, 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neander_mem_resp;

    localparam int NI = 3;

`ifdef NEANDER_MEM_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    function automatic int wt(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    logic       clock = 1'b0;
    logic       RESET;
    logic       read, write, ld_we;
    logic [7:0] endM, dataIN, ld_addr, ld_data;
    logic [7:0] dout [NI];
    logic       rdy  [NI];
    logic       ldr  [NI];
`ifdef NEANDER_MEM_IO_EN
    logic [7:0] iov  [NI];
`endif

    always #5 clock = ~clock;

    neander_mem_resp #(.WAIT_CYCLES(0), .DATA_W(8)) u_w0 (
        .clock(clock), .RESET(RESET), .endM(endM), .dataIN(dataIN),
        .read(read), .write(write), .dataOUT(dout[0]), .ready(rdy[0]),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef NEANDER_MEM_IO_EN
        .io_out(iov[0]),
`endif
        .ld_rdy(ldr[0]));

    neander_mem_resp #(.WAIT_CYCLES(1), .DATA_W(8)) u_w1 (
        .clock(clock), .RESET(RESET), .endM(endM), .dataIN(dataIN),
        .read(read), .write(write), .dataOUT(dout[1]), .ready(rdy[1]),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef NEANDER_MEM_IO_EN
        .io_out(iov[1]),
`endif
        .ld_rdy(ldr[1]));

    neander_mem_resp #(.WAIT_CYCLES(3), .DATA_W(8)) u_w3 (
        .clock(clock), .RESET(RESET), .endM(endM), .dataIN(dataIN),
        .read(read), .write(write), .dataOUT(dout[2]), .ready(rdy[2]),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef NEANDER_MEM_IO_EN
        .io_out(iov[2]),
`endif
        .ld_rdy(ldr[2]));

    // Behavioural model: a pending access carries the number of edges left
    // until it completes; completion raises ready for the following cycle.
    bit         m_pend [NI];
    bit         m_rdy  [NI];
    bit         m_wr   [NI];
    int         m_left [NI];
    logic [7:0] m_addr [NI];
    logic [7:0] m_data [NI];
    logic [7:0] m_dout [NI];
    logic [7:0] m_io   [NI];
    logic [7:0] m_mem  [NI][256];

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    int first_rdy [NI];
    int n_rdy     [NI];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s W=%0d actual=%0h required=%0h t=%0t", nm, wt(i), act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            if (RESET) begin
                m_pend[i] = 1'b0;
                m_rdy[i]  = 1'b0;
                m_left[i] = 0;
                m_dout[i] = 8'h00;
                m_io[i]   = 8'h00;
            end else if (m_rdy[i]) begin
                m_rdy[i] = 1'b0;
            end else if (m_pend[i]) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_pend[i] = 1'b0;
                    m_rdy[i]  = 1'b1;
                    if (m_wr[i]) begin
                        if (IO_EN && m_addr[i] == 8'hFF) m_io[i] = m_data[i];
                        else m_mem[i][m_addr[i]] = m_data[i];
                    end else begin
                        m_dout[i] = (IO_EN && m_addr[i] == 8'hFF) ? m_io[i] : m_mem[i][m_addr[i]];
                    end
                end
            end else if (ld_we) begin
                m_mem[i][ld_addr] = ld_data;
            end else if (write || read) begin
                m_pend[i] = 1'b1;
                m_wr[i]   = write;
                m_addr[i] = endM;
                m_data[i] = dataIN;
                m_left[i] = wt(i) + 1;
            end
        end
    endtask

    // One clock: advance the model over the coming edge, then compare at the
    // falling edge.
    task automatic step();
        model_step();
        @(negedge clock);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            chk("ready", i, 32'(rdy[i]), 32'(m_rdy[i]));
            chk("dataOUT", i, 32'(dout[i]), 32'(m_dout[i]));
            chk("ld_rdy", i, 32'(ldr[i]), 32'(!m_pend[i] && !m_rdy[i]));
`ifdef NEANDER_MEM_IO_EN
            chk("io_out", i, 32'(iov[i]), 32'(m_io[i]));
`endif
            if (rdy[i]) begin
                n_rdy[i]++;
                if (first_rdy[i] < 0) first_rdy[i] = cyc;
            end
        end
    endtask

    task automatic idle_in();
        RESET = 1'b0; read = 1'b0; write = 1'b0; ld_we = 1'b0;
    endtask

    task automatic open_win();
        cyc = 0;
        for (int i = 0; i < NI; i++) begin
            first_rdy[i] = -1;
            n_rdy[i]     = 0;
        end
    endtask

    task automatic pulse(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
        read = rd; write = wr; endM = a; dataIN = d;
        open_win();
        step();
        idle_in();
        repeat (7) step();
        for (int i = 0; i < NI; i++) begin
            chk("latency", i, 32'(first_rdy[i]), 32'(wt(i) + 2));
            chk("ready_pulses", i, 32'(n_rdy[i]), 32'd1);
        end
    endtask

    initial begin
        RESET = 1'b1; read = 1'b0; write = 1'b0; ld_we = 1'b0;
        endM = 8'h00; dataIN = 8'h00; ld_addr = 8'h00; ld_data = 8'h00;
        open_win();
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            chk("rst_ready", i, 32'(rdy[i]), 32'd0);
            chk("rst_dataOUT", i, 32'(dout[i]), 32'h00);
            chk("rst_ld_rdy", i, 32'(ldr[i]), 32'd1);
        end
        idle_in();

        // Preload every word with addr^0x5A, then 0x3C at 0x10.
        for (int a = 0; a < 256; a++) begin
            ld_we = 1'b1; ld_addr = 8'(a); ld_data = 8'(a) ^ 8'h5A;
            step();
        end
        ld_addr = 8'h10; ld_data = 8'h3C;
        step();
        idle_in();

        pulse(1'b1, 1'b0, 8'h10, 8'h00);
        for (int i = 0; i < NI; i++) chk("read_0x10", i, 32'(dout[i]), 32'h3C);
        pulse(1'b0, 1'b1, 8'h80, 8'hA5);
        for (int i = 0; i < NI; i++) chk("dout_held_wr", i, 32'(dout[i]), 32'h3C);
        pulse(1'b1, 1'b0, 8'h80, 8'h00);
        for (int i = 0; i < NI; i++) chk("read_0x80", i, 32'(dout[i]), 32'hA5);
        pulse(1'b1, 1'b1, 8'h20, 8'h77);
        for (int i = 0; i < NI; i++) chk("dout_held_rdwr", i, 32'(dout[i]), 32'hA5);
        pulse(1'b1, 1'b0, 8'h20, 8'h00);
        for (int i = 0; i < NI; i++) chk("read_0x20", i, 32'(dout[i]), 32'h77);

        // Loader wins over a simultaneous read; a loader write while busy is lost.
        ld_we = 1'b1; ld_addr = 8'h05; ld_data = 8'h11; read = 1'b1; endM = 8'h05;
        open_win();
        step();
        ld_we = 1'b0;
        step();
        read = 1'b0; ld_we = 1'b1; ld_addr = 8'h05; ld_data = 8'hEE;
        step();
        ld_we = 1'b0;
        repeat (6) step();
        for (int i = 0; i < NI; i++) begin
            chk("ld_first_latency", i, 32'(first_rdy[i]), 32'(wt(i) + 3));
            chk("ld_read_0x05", i, 32'(dout[i]), 32'h11);
        end
        pulse(1'b1, 1'b0, 8'h05, 8'h00);
        for (int i = 0; i < NI; i++) chk("busy_ld_lost", i, 32'(dout[i]), 32'h11);

        // Reset in the second wait cycle of the WAIT_CYCLES=3 instance.
        write = 1'b1; endM = 8'h40; dataIN = 8'h55;
        open_win();
        step();
        write = 1'b0; endM = 8'h41; dataIN = 8'hFF;
        step();
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("abort_ld_rdy", 2, 32'(ldr[2]), 32'd1);
        chk("abort_dataOUT", 2, 32'(dout[2]), 32'h00);
        repeat (4) step();
        chk("abort_no_ready", 2, 32'(n_rdy[2]), 32'd0);
        pulse(1'b1, 1'b0, 8'h40, 8'h00);
        for (int i = 0; i < NI; i++)
            chk("abort_0x40", i, 32'(dout[i]), (wt(i) == 3) ? 32'h1A : 32'h55);
        pulse(1'b1, 1'b0, 8'h41, 8'h00);
        for (int i = 0; i < NI; i++) chk("abort_0x41", i, 32'(dout[i]), 32'h1B);

`ifdef NEANDER_MEM_IO_EN
        pulse(1'b0, 1'b1, 8'hFF, 8'h9C);
        for (int i = 0; i < NI; i++) chk("io_write", i, 32'(iov[i]), 32'h9C);
        pulse(1'b1, 1'b0, 8'hFF, 8'h00);
        for (int i = 0; i < NI; i++) chk("io_read", i, 32'(dout[i]), 32'h9C);
`endif

        // Randomised traffic, small address pool plus 0xFF for collisions.
        for (int n = 0; n < 3000; n++) begin
            RESET   = ($urandom_range(0, 199) == 0);
            ld_we   = ($urandom_range(0, 4) == 0);
            read    = ($urandom_range(0, 2) == 0);
            write   = ($urandom_range(0, 2) == 0);
            endM    = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            dataIN  = 8'($urandom);
            ld_addr = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            ld_data = 8'($urandom);
            step();
        end
        idle_in();
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
